spi_multi_lane_master: RTL and testbench

//  Synthesizable SPI master for the spi_if pin set: sclk, per-slave active-low chip select,
//  and four unidirectional MOSI/MISO lanes. Supports single, dual and quad lane modes,
//  all four CPOL/CPHA modes, a programmable sclk divider and NUM_CS slaves.

---
 rtl/spi_multi_lane_master.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_spi_multi_lane_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_multi_lane_master.sv
// SPI master with single/dual/quad lanes, all CPOL/CPHA modes, programmable
// sclk divider and NUM_CS active-low chip selects behind a valid/ready command port.
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input (LSB-first bit order).
module spi_multi_lane_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned DIV_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      ready,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    input  logic [$clog2(NUM_CS)-1:0] cs_sel,
    input  logic [1:0]                lane_mode,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic [DIV_W-1:0]          clk_div,
`ifdef SPI_LSB_FIRST_EN
    input  logic                      lsb_first,
`endif
    output logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      rx_valid,
    output logic                      busy,
    output logic                      sclk,
    output logic [NUM_CS-1:0]         cs_n,
    output logic [3:0]                mosi,
    input  logic [3:0]                miso
);

    localparam int unsigned W      = DATA_WIDTH;
    localparam int unsigned HALF_W = $clog2(2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Lane-mode encodings after normalisation (11 folds onto single)
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [HALF_W-1:0]   half_last_q, half_last_d;
    logic [1:0]          mode_q, mode_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [W-1:0]        tx_sh_q, tx_sh_d;
    logic [W-1:0]        rx_sh_q, rx_sh_d;
    logic [W-1:0]        rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic [3:0]          mosi_q, mosi_d;
    logic                lsb_q;
    logic                lsb_in_c;
    logic [1:0]          mode_in_c;
    logic                edge_c;
    logic                edge_lead_c;

`ifdef SPI_LSB_FIRST_EN
    logic                lsb_d;
    assign lsb_in_c = lsb_first;
`else
    assign lsb_in_c = 1'b0;
    assign lsb_q    = 1'b0;
`endif

    // Bits presented on mosi for the next sclk cycle, lane-aligned
    function automatic logic [3:0] chunk_f(input logic [W-1:0] w, input logic [1:0] m,
                                           input logic lsb);
        case (m)
            MODE_DUAL: chunk_f = lsb ? {2'b00, w[1:0]} : {2'b00, w[W-1:W-2]};
            MODE_QUAD: chunk_f = lsb ? w[3:0] : w[W-1:W-4];
            default:   chunk_f = lsb ? {3'b000, w[0]} : {3'b000, w[W-1]};
        endcase
    endfunction

    // Discard the bits just presented
    function automatic logic [W-1:0] shift_f(input logic [W-1:0] w, input logic [1:0] m,
                                             input logic lsb);
        case (m)
            MODE_DUAL: shift_f = lsb ? (w >> 2) : (w << 2);
            MODE_QUAD: shift_f = lsb ? (w >> 4) : (w << 4);
            default:   shift_f = lsb ? (w >> 1) : (w << 1);
        endcase
    endfunction

    // Merge sampled miso lanes into the receive shifter
    function automatic logic [W-1:0] insert_f(input logic [W-1:0] r, input logic [3:0] d,
                                              input logic [1:0] m, input logic lsb);
        case (m)
            MODE_DUAL: insert_f = lsb ? {d[1:0], r[W-1:2]} : {r[W-3:0], d[1:0]};
            MODE_QUAD: insert_f = lsb ? {d[3:0], r[W-1:4]} : {r[W-5:0], d[3:0]};
            default:   insert_f = lsb ? {d[0], r[W-1:1]} : {r[W-2:0], d[0]};
        endcase
    endfunction

    // Normalise incoming lane mode so 11 behaves exactly like single
    always_comb begin
        mode_in_c = (lane_mode == 2'b11) ? MODE_SINGLE : lane_mode;
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        half_d      = half_q;
        half_last_d = half_last_q;
        mode_d      = mode_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        edge_c      = 1'b0;
        edge_lead_c = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_d       = lsb_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    half_d  = '0;
                    div_d   = clk_div;
                    mode_d  = mode_in_c;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                    case (mode_in_c)
                        MODE_DUAL: half_last_d = HALF_W'(W - 1);
                        MODE_QUAD: half_last_d = HALF_W'(W / 2 - 1);
                        default:   half_last_d = HALF_W'(2 * W - 1);
                    endcase
                    sclk_d  = cpol;
                    cs_n_d  = ~(NUM_CS'(1) << cs_sel);
                    rx_sh_d = '0;
                    // cpha=0 presents the first bits before the leading edge
                    if (cpha) begin
                        mosi_d  = 4'h0;
                        tx_sh_d = tx_data;
                    end else begin
                        mosi_d  = chunk_f(tx_data, mode_in_c, lsb_in_c);
                        tx_sh_d = shift_f(tx_data, mode_in_c, lsb_in_c);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == div_q) begin
                    state_d     = XFER;
                    cnt_d       = '0;
                    half_d      = '0;
                    edge_c      = 1'b1;
                    edge_lead_c = 1'b1;
                end else begin
                    cnt_d = DIV_W'(cnt_q + 1'b1);
                end
            end
            XFER: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (half_q == half_last_q) begin
                        state_d = HOLD;
                        sclk_d  = cpol_q;
                    end else begin
                        half_d      = HALF_W'(half_q + 1'b1);
                        edge_c      = 1'b1;
                        edge_lead_c = half_q[0];
                    end
                end else begin
                    cnt_d = DIV_W'(cnt_q + 1'b1);
                end
            end
            HOLD: begin
                if (cnt_q == div_q) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    cs_n_d     = '1;
                    mosi_d     = 4'h0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                end else begin
                    cnt_d = DIV_W'(cnt_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase

        // On each sclk edge either shift mosi or sample miso, chosen by cpha
        if (edge_c) begin
            sclk_d = ~sclk_q;
            if (edge_lead_c == cpha_q) begin
                mosi_d  = chunk_f(tx_sh_q, mode_q, lsb_q);
                tx_sh_d = shift_f(tx_sh_q, mode_q, lsb_q);
            end else begin
                rx_sh_d = insert_f(rx_sh_q, miso, mode_q, lsb_q);
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            half_q      <= '0;
            half_last_q <= '0;
            mode_q      <= MODE_SINGLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= '1;
            mosi_q      <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            half_q      <= half_d;
            half_last_q <= half_last_d;
            mode_q      <= mode_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
        end
    end

`ifdef SPI_LSB_FIRST_EN
    // Latched bit-order selection
    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else begin
            lsb_q <= lsb_d;
        end
    end
`endif

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_multi_lane_master.sv
// Scoreboard bench for spi_multi_lane_master: directed commands push expected
// rx words and arrival cycles; a negedge monitor pops and compares on rx_valid.
module tb_spi_multi_lane_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ready;
    logic [7:0] tx_data;
    logic [1:0] cs_sel;
    logic [1:0] lane_mode;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_first;
`endif
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic [3:0] cs_n;
    logic [3:0] mosi;
    logic [3:0] miso;
    logic       loop;
    logic [3:0] miso_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t sb_q[$];

    spi_multi_lane_master #(
        .DATA_WIDTH(8),
        .NUM_CS(4),
        .DIV_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ready(ready),
        .tx_data(tx_data),
        .cs_sel(cs_sel),
        .lane_mode(lane_mode),
        .cpol(cpol),
        .cpha(cpha),
        .clk_div(clk_div),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .sclk(sclk),
        .cs_n(cs_n),
        .mosi(mosi),
        .miso(miso)
    );

    // Slave model: loopback of mosi or a constant pattern
    assign miso = loop ? mosi : miso_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rx_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rx_valid: got rx_data 0x%0h at cycle %0d want none", rx_data, cyc);
            end else begin
                e = sb_q.pop_front();
                check("rx_data", rx_data, e.data);
                check("rx_cycle", cyc, e.when);
            end
        end
    end

    task automatic xfer(input logic [7:0] tx, input int cs, input logic [1:0] mode,
                        input logic pol, input logic pha, input int div, input logic lb,
                        input logic [3:0] mc, input logic lsb, input logic [7:0] exp_rx,
                        input string tag);
        int         l;
        int         n;
        int         t;
        int         leads;
        logic [7:0] seen;
        logic [3:0] mask;
        logic [3:0] exp_cs;
        logic [7:0] bits;
        logic       prev;
        logic       unused_hot;
        bit         done;
        exp_t       e;
        l    = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
        n    = 8 / l;
        mask = (l == 1) ? 4'h1 : (l == 2) ? 4'h3 : 4'hF;
        exp_cs = ~(4'b0001 << cs);
        @(negedge clk);
        tx_data   = tx;
        cs_sel    = 2'(cs);
        lane_mode = mode;
        cpol      = pol;
        cpha      = pha;
        clk_div   = 8'(div);
        loop      = lb;
        miso_c    = mc;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        start     = 1'b1;
        t         = cyc;
        e.data    = exp_rx;
        e.when    = t + 1 + (2 * n + 2) * (div + 1);
        sb_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        tx_data = ~tx;
        cpol    = ~pol;
        check({tag, "_cs_n_setup"}, cs_n, exp_cs);
        check({tag, "_sclk_setup"}, sclk, pol);
        leads      = 0;
        seen       = 8'h00;
        prev       = sclk;
        unused_hot = 1'b0;
        done       = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (rx_valid) begin
                done = 1'b1;
            end else begin
                if (sclk !== prev && sclk !== pol) begin
                    bits = 8'(mosi & mask);
                    if ((mosi & ~mask) != 4'h0) unused_hot = 1'b1;
                    if (lsb) seen = seen | 8'(bits << (leads * l));
                    else     seen = 8'((seen << l) | bits);
                    leads++;
                end
                prev = sclk;
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no rx_valid want one", tag);
        end else begin
            check({tag, "_sclk_idle"}, sclk, pol);
            check({tag, "_cs_n_end"}, cs_n, 4'hF);
            check({tag, "_ready_end"}, ready, 1'b1);
        end
        check({tag, "_leading_edges"}, leads, n);
        check({tag, "_mosi_word"}, seen, tx);
        check({tag, "_unused_lanes"}, unused_hot, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 5000 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: got %0d pending want 0", tag, sb_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   edges;
        logic prev;
        exp_t e;
        rst       = 1'b1;
        start     = 1'b0;
        tx_data   = 8'h00;
        cs_sel    = 2'd0;
        lane_mode = 2'b00;
        cpol      = 1'b0;
        cpha      = 1'b0;
        clk_div   = 8'd0;
        loop      = 1'b1;
        miso_c    = 4'h0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_sclk", sclk, 1'b0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_mosi", mosi, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // tx, cs, mode, cpol, cpha, div, loop, miso, lsb, expected rx
        xfer(8'hA5, 0, 2'b00, 1'b0, 1'b0, 0,   1'b1, 4'h0, 1'b0, 8'hA5, "single_m0");
        xfer(8'h3C, 0, 2'b10, 1'b0, 1'b0, 1,   1'b0, 4'h9, 1'b0, 8'h99, "quad_m0");
        xfer(8'h96, 2, 2'b01, 1'b1, 1'b1, 0,   1'b1, 4'h0, 1'b0, 8'h96, "dual_m3");
        xfer(8'h4B, 1, 2'b00, 1'b0, 1'b1, 2,   1'b1, 4'h0, 1'b0, 8'h4B, "single_m1");
        xfer(8'hC3, 3, 2'b11, 1'b1, 1'b0, 0,   1'b1, 4'h0, 1'b0, 8'hC3, "mode11_m2");
        xfer(8'h5A, 0, 2'b01, 1'b0, 1'b0, 0,   1'b0, 4'hE, 1'b0, 8'hAA, "dual_const");
        xfer(8'hE7, 1, 2'b10, 1'b0, 1'b1, 255, 1'b1, 4'h0, 1'b0, 8'hE7, "quad_divmax");
`ifdef SPI_LSB_FIRST_EN
        xfer(8'h01, 0, 2'b00, 1'b0, 1'b0, 0,   1'b1, 4'h0, 1'b1, 8'h01, "lsb_single");
        xfer(8'h3C, 0, 2'b10, 1'b0, 1'b0, 0,   1'b0, 4'h6, 1'b1, 8'h66, "lsb_quad");
`endif
        wait_drain("directed");

        // start held high while busy: ignored, then accepted back-to-back
        @(negedge clk);
        tx_data   = 8'h5A;
        cs_sel    = 2'd0;
        lane_mode = 2'b00;
        cpol      = 1'b0;
        cpha      = 1'b0;
        clk_div   = 8'd0;
        loop      = 1'b1;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        start     = 1'b1;
        t         = cyc;
        e.data    = 8'h5A;
        e.when    = t + 19;
        sb_q.push_back(e);
        @(negedge clk);
        tx_data = 8'hFF;
        for (int i = 0; i < 100 && cyc < t + 19; i++) @(negedge clk);
        check("b2b_ready_at_end", ready, 1'b1);
        check("b2b_cs_n_gap", cs_n, 4'hF);
        e.data = 8'hFF;
        e.when = t + 38;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_again", busy, 1'b1);
        check("b2b_cs_n_again", cs_n, 4'b1110);
        wait_drain("b2b");

        // reset after the 4th sclk edge aborts the transfer
        @(negedge clk);
        tx_data   = 8'h33;
        cs_sel    = 2'd1;
        lane_mode = 2'b00;
        cpol      = 1'b0;
        cpha      = 1'b0;
        clk_div   = 8'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        prev  = sclk;
        for (int i = 0; i < 200 && edges < 4; i++) begin
            @(negedge clk);
            if (sclk !== prev) edges++;
            prev = sclk;
        end
        check("abort_edges_seen", edges, 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n", cs_n, 4'hF);
        check("abort_sclk", sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 1'b1);
        check("abort_mosi", mosi, 4'h0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_pending", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
